// File: rtl/l2_bank_rr_arbiter.sv
// Round-robin arbiter feeding one L2 SRAM bank, routing responses back through an outstanding-ID FIFO.
// Optional stall counter enabled by defining L2_ARB_STALL_CNT_EN.
module l2_bank_rr_arbiter #(
   parameter int NB_MASTERS = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RSP_DEPTH  = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NB_MASTERS-1:0]            mst_req_i,
   input  logic [NB_MASTERS*ADDR_WIDTH-1:0] mst_add_i,
   input  logic [NB_MASTERS-1:0]            mst_wen_i,
   input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] mst_be_i,
   input  logic [NB_MASTERS*DATA_WIDTH-1:0] mst_wdata_i,
   output logic [NB_MASTERS-1:0]            mst_gnt_o,
   output logic [NB_MASTERS-1:0]            mst_r_valid_o,
   output logic [DATA_WIDTH-1:0]            mst_r_rdata_o,
   output logic                             mst_r_opc_o,
   output logic                             bank_req_o,
   output logic [ADDR_WIDTH-1:0]            bank_add_o,
   output logic                             bank_wen_o,
   output logic [DATA_WIDTH/8-1:0]          bank_be_o,
   output logic [DATA_WIDTH-1:0]            bank_wdata_o,
   input  logic                             bank_gnt_i,
   input  logic                             bank_r_valid_i,
   input  logic [DATA_WIDTH-1:0]            bank_r_rdata_i,
   input  logic                             bank_r_opc_i,
   output logic                             err_o,
   output logic [CNT_WIDTH-1:0]             stall_cnt_o,
   input  logic                             stall_cnt_clr_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_W    = $clog2(NB_MASTERS);
   localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int OCC_W    = $clog2(RSP_DEPTH + 1);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win;
   logic [IDX_W-1:0] win_hi;
   logic [IDX_W-1:0] win_lo;
   logic             hi_found;
   logic             any_req;
   logic             gnt;

   logic [IDX_W-1:0] id_mem [RSP_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             can_push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fifo_empty = (occ == '0);
   assign fifo_full  = (occ == OCC_W'(RSP_DEPTH));
   assign pop        = bank_r_valid_i & ~fifo_empty;
   assign can_push   = ~fifo_full | pop;
   assign any_req    = |mst_req_i;
   assign bank_req_o = any_req & can_push;
   assign gnt        = bank_req_o & bank_gnt_i;

   // Scan downwards so the last hit is the lowest index: win_hi is the first
   // requester at or above rr_ptr, win_lo the wrap-around fallback.
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      hi_found = 1'b0;
      for (int i = NB_MASTERS - 1; i >= 0; i--) begin
         if (mst_req_i[i]) begin
            win_lo = IDX_W'(i);
            if (IDX_W'(i) >= rr_ptr) begin
               win_hi   = IDX_W'(i);
               hi_found = 1'b1;
            end
         end
      end
      win = hi_found ? win_hi : win_lo;
   end

   always_comb begin
      bank_add_o    = '0;
      bank_wen_o    = 1'b0;
      bank_be_o     = '0;
      bank_wdata_o  = '0;
      mst_gnt_o     = '0;
      mst_r_valid_o = '0;
      for (int i = 0; i < NB_MASTERS; i++) begin
         if (bank_req_o && (win == IDX_W'(i))) begin
            bank_add_o   = mst_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            bank_wen_o   = mst_wen_i[i];
            bank_be_o    = mst_be_i[i*BE_WIDTH +: BE_WIDTH];
            bank_wdata_o = mst_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
         mst_gnt_o[i]     = gnt && (win == IDX_W'(i));
         mst_r_valid_o[i] = pop && (id_mem[rd_ptr] == IDX_W'(i));
      end
   end

   assign mst_r_rdata_o = bank_r_rdata_i;
   assign mst_r_opc_o   = bank_r_opc_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         err_o  <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) id_mem[i] <= '0;
      end else begin
         if (gnt) begin
            id_mem[wr_ptr] <= win;
            wr_ptr         <= ptr_inc(wr_ptr);
            rr_ptr         <= (win == IDX_W'(NB_MASTERS - 1)) ? '0 : win + 1'b1;
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({gnt, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         // A response with nothing outstanding is dropped and flagged until reset.
         if (bank_r_valid_i && fifo_empty) err_o <= 1'b1;
      end
   end

`ifdef L2_ARB_STALL_CNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_o <= '0;
      end else if (stall_cnt_clr_i) begin
         stall_cnt_o <= '0;
      end else if (|(mst_req_i & ~mst_gnt_o) && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end
`else
   logic unused_stall_clr;
   assign unused_stall_clr = stall_cnt_clr_i;
   assign stall_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// Self-checking bench for l2_bank_rr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_l2_bank_rr_arbiter;
   localparam int NB = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RD = 2;
   localparam int CW = 32;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [NB-1:0]     mst_req_i;
   logic [NB*AW-1:0]  mst_add_i;
   logic [NB-1:0]     mst_wen_i;
   logic [NB*DW/8-1:0] mst_be_i;
   logic [NB*DW-1:0]  mst_wdata_i;
   logic [NB-1:0]     mst_gnt_o;
   logic [NB-1:0]     mst_r_valid_o;
   logic [DW-1:0]     mst_r_rdata_o;
   logic              mst_r_opc_o;
   logic              bank_req_o;
   logic [AW-1:0]     bank_add_o;
   logic              bank_wen_o;
   logic [DW/8-1:0]   bank_be_o;
   logic [DW-1:0]     bank_wdata_o;
   logic              bank_gnt_i;
   logic              bank_r_valid_i;
   logic [DW-1:0]     bank_r_rdata_i;
   logic              bank_r_opc_i;
   logic              err_o;
   logic [CW-1:0]     stall_cnt_o;
   logic              stall_cnt_clr_i;

   l2_bank_rr_arbiter #(.NB_MASTERS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .RSP_DEPTH(RD), .CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .mst_req_i(mst_req_i), .mst_add_i(mst_add_i), .mst_wen_i(mst_wen_i),
      .mst_be_i(mst_be_i), .mst_wdata_i(mst_wdata_i),
      .mst_gnt_o(mst_gnt_o), .mst_r_valid_o(mst_r_valid_o),
      .mst_r_rdata_o(mst_r_rdata_o), .mst_r_opc_o(mst_r_opc_o),
      .bank_req_o(bank_req_o), .bank_add_o(bank_add_o), .bank_wen_o(bank_wen_o),
      .bank_be_o(bank_be_o), .bank_wdata_o(bank_wdata_o),
      .bank_gnt_i(bank_gnt_i), .bank_r_valid_i(bank_r_valid_i),
      .bank_r_rdata_i(bank_r_rdata_i), .bank_r_opc_i(bank_r_opc_i),
      .err_o(err_o), .stall_cnt_o(stall_cnt_o), .stall_cnt_clr_i(stall_cnt_clr_i)
   );

   always #5 clk_i = ~clk_i;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   int          m_rr;
   int          m_q[$];
   bit          m_err;
   logic [CW-1:0] m_stall;
   bit          m_granted;

   logic [NB-1:0] obs_gnt, obs_rv;
   logic [AW-1:0] obs_add;
   logic [DW-1:0] obs_rdata;
   logic          obs_req;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks all outputs against the model, then advances the model across one edge.
   task automatic cycle();
      int w;
      bit pop, ereq;
      logic [NB-1:0] eg, ev;
      #1;
      pop = bank_r_valid_i && (m_q.size() > 0);
      ev  = pop ? (4'b0001 << m_q[0]) : 4'b0000;
      w = -1;
      for (int j = 0; j < NB; j++)
         if (w < 0 && mst_req_i[(m_rr + j) % NB]) w = (m_rr + j) % NB;
      ereq = (w >= 0) && ((m_q.size() < RD) || pop);
      eg   = (ereq && bank_gnt_i) ? (4'b0001 << w) : 4'b0000;
      obs_gnt = mst_gnt_o; obs_rv = mst_r_valid_o; obs_add = bank_add_o;
      obs_rdata = mst_r_rdata_o; obs_req = bank_req_o;
      chk("bank_req", bank_req_o, ereq);
      chk("gnt", mst_gnt_o, eg);
      chk("r_valid", mst_r_valid_o, ev);
      chk("bank_add", bank_add_o, ereq ? mst_add_i[w*AW +: AW] : '0);
      chk("bank_wen", bank_wen_o, ereq ? mst_wen_i[w] : 1'b0);
      chk("bank_be", bank_be_o, ereq ? mst_be_i[w*4 +: 4] : '0);
      chk("bank_wdata", bank_wdata_o, ereq ? mst_wdata_i[w*DW +: DW] : '0);
      chk("rdata", mst_r_rdata_o, bank_r_rdata_i);
      chk("opc", mst_r_opc_o, bank_r_opc_i);
      chk("err", err_o, m_err);
      chk("stall", stall_cnt_o, m_stall);
      @(posedge clk_i);
`ifdef L2_ARB_STALL_CNT_EN
      if (stall_cnt_clr_i) m_stall = '0;
      else if (((mst_req_i & ~eg) != 0) && (m_stall != '1)) m_stall = m_stall + 1;
`endif
      if (bank_r_valid_i && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      m_granted = (eg != 0);
      if (eg != 0) begin
         m_q.push_back(w);
         m_rr = (w + 1) % NB;
      end
      #1;
   endtask

   task automatic set_idle();
      mst_req_i = '0; bank_gnt_i = 1'b1; bank_r_valid_i = 1'b0;
      bank_r_opc_i = 1'b0; stall_cnt_clr_i = 1'b0;
   endtask

   task automatic model_reset();
      m_rr = 0; m_q.delete(); m_err = 1'b0; m_stall = '0; m_granted = 1'b0;
   endtask

   // Asserts reset between clock edges; callers arrive 1 time unit after an edge.
   task automatic do_reset();
      #3 rst_ni = 1'b0;
      model_reset();
      #1;
      chk("rst_err", err_o, 1'b0);
      chk("rst_stall", stall_cnt_o, '0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
   endtask

   task automatic rand_payload();
      for (int i = 0; i < NB; i++) begin
         mst_add_i[i*AW +: AW]   = $urandom;
         mst_wdata_i[i*DW +: DW] = $urandom;
      end
      mst_wen_i      = 4'($urandom);
      mst_be_i       = 16'($urandom);
      bank_r_rdata_i = $urandom;
   endtask

   initial begin
      rst_ni = 1'b0;
      set_idle();
      rand_payload();
      model_reset();
      #2;
      chk("por_gnt", mst_gnt_o, 4'b0000);
      chk("por_bank_req", bank_req_o, 1'b0);
      chk("por_err", err_o, 1'b0);
      @(posedge clk_i); #1 rst_ni = 1'b1;

      // Single master read
      mst_req_i = 4'b0100; mst_add_i[2*AW +: AW] = 32'h1C000004; mst_wen_i[2] = 1'b1;
      cycle();
      chk("t1_add", obs_add, 32'h1C000004);
      chk("t1_gnt", obs_gnt, 4'b0100);
      mst_req_i = '0; bank_r_valid_i = 1'b1; bank_r_rdata_i = 32'hCAFEF00D;
      cycle();
      chk("t1_rv", obs_rv, 4'b0100);
      chk("t1_rdata", obs_rdata, 32'hCAFEF00D);

      // rr_ptr now 3: m3 beats m1, then m1 wins
      mst_req_i = 4'b1010; bank_r_valid_i = 1'b0;
      cycle();
      chk("t3_first", obs_gnt, 4'b1000);
      bank_r_valid_i = 1'b1;
      cycle();
      chk("t3_second", obs_gnt, 4'b0010);
      chk("t3_rv_m3", obs_rv, 4'b1000);
      mst_req_i = '0;
      cycle();
      chk("t3_rv_m1", obs_rv, 4'b0010);
      bank_r_valid_i = 1'b0;

      // All masters request for 8 cycles, bank answers one cycle after each grant
      do_reset();
      mst_req_i = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         bank_r_valid_i = m_granted;
         cycle();
         chk("t2_order", obs_gnt, 4'b0001 << (k % 4));
      end
      mst_req_i = '0; bank_r_valid_i = m_granted;
      cycle();
      bank_r_valid_i = 1'b0;

      // Bank withholds grant for 3 cycles
      stall_cnt_clr_i = 1'b1;
      cycle();
      stall_cnt_clr_i = 1'b0;
      mst_req_i = 4'b0001; bank_gnt_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("t4_nognt", obs_gnt, 4'b0000);
         chk("t4_req", obs_req, 1'b1);
      end
      mst_req_i = '0; bank_gnt_i = 1'b1;
      cycle();
`ifdef L2_ARB_STALL_CNT_EN
      chk("t4_stall", stall_cnt_o, 32'd3);
`else
      chk("t4_stall", stall_cnt_o, 32'd0);
`endif

      // Responses delayed by 2 cycles: FIFO fills, request drops, resumes on first pop
      mst_req_i = 4'b0001;
      begin
         logic [3:0] rv_seq, req_seq;
         rv_seq = 4'b1000; req_seq = 4'b1011;
         for (int k = 0; k < 4; k++) begin
            bank_r_valid_i = rv_seq[k];
            cycle();
            chk("t5_req", obs_req, req_seq[k]);
         end
      end
      mst_req_i = '0; bank_r_valid_i = 1'b1;
      cycle(); cycle();
      bank_r_valid_i = 1'b0;

      // Spurious response, then reset mid-burst
      do_reset();
      bank_r_valid_i = 1'b1;
      cycle();
      chk("t6_drop", obs_rv, 4'b0000);
      bank_r_valid_i = 1'b0;
      cycle();
      chk("t6_err", err_o, 1'b1);
      mst_req_i = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         bank_r_valid_i = m_granted;
         cycle();
      end
      bank_r_valid_i = 1'b0;
      do_reset();
      chk("t6_err_clr", err_o, 1'b0);
      mst_req_i = 4'b1001;
      cycle();
      chk("t6_rr0", obs_gnt, 4'b0001);
      mst_req_i = '0; bank_r_valid_i = 1'b1;
      cycle();
      chk("t6_rv_m0", obs_rv, 4'b0001);
      cycle();
      chk("t6_empty", obs_rv, 4'b0000);
      bank_r_valid_i = 1'b0;
      do_reset();

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         rand_payload();
         mst_req_i       = 4'($urandom);
         bank_gnt_i      = ($urandom_range(0, 3) != 0);
         bank_r_opc_i    = 1'($urandom);
         stall_cnt_clr_i = ($urandom_range(0, 15) == 0);
         if (m_q.size() > 0) bank_r_valid_i = ($urandom_range(0, 2) != 0);
         else                bank_r_valid_i = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 199) == 0) do_reset();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
